inst_rom_ctrl: RTL and testbench

//  Responder for the core's instruction-fetch port (rom_addr/rom_en -> inst). Holds the word-wide

---
 rtl/inst_rom_ctrl.sv | 115 +++++++++++
 tb/tb_inst_rom_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_ctrl.sv
// Instruction ROM responder with a streaming loader. It holds the core in reset
// until a complete image has been written, then serves zero-latency fetches.
module inst_rom_ctrl #(
  parameter int          AW  = 10,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   rom_addr_i,
  input  logic          rom_en_i,
  output logic [31:0]   inst_o,
  input  logic          ld_start_i,
  input  logic          ld_valid_i,
  input  logic [31:0]   ld_data_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  output logic          ld_done_o,
  output logic [AW:0]   ld_cnt_o,
  output logic          ld_ovf_o,
  output logic          addr_err_o,
  output logic          core_hold_o
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_LOAD,
    S_DONE,
    S_RUN
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_n;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          err_q;
  logic          hold_core_q;
  logic [31:0]   hold_inst_q;
  logic [31:0]   mem [0:(1<<AW)-1];

  logic          beat;
  logic          cnt_full;
  logic          load_entry;
  logic          fetch_bad;
  logic [AW-1:0] idx;

  assign ld_ready_o  = (state_q == S_LOAD);
  assign ld_done_o   = (state_q == S_DONE);
  assign ld_cnt_o    = cnt_q;
  assign ld_ovf_o    = ovf_q;
  assign addr_err_o  = err_q;
  assign core_hold_o = hold_core_q;

  assign beat       = ld_valid_i & ld_ready_o;
  assign cnt_full   = (cnt_q == DEPTH);
  assign load_entry = (state_n == S_LOAD) && (state_q != S_LOAD);
  assign idx        = rom_addr_i[AW+1:2];
  assign fetch_bad  = (|rom_addr_i[1:0]) | (|rom_addr_i[31:AW+2]);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_HOLD:  if (ld_start_i) state_n = S_LOAD;
      S_LOAD:  if (beat && ld_last_i) state_n = S_DONE;
      S_DONE:  state_n = S_RUN;
      S_RUN:   if (ld_start_i) state_n = S_LOAD;
      default: state_n = S_HOLD;
    endcase
  end

  always_comb begin
    inst_o = NOP;
    if (state_q == S_RUN) begin
      if (!rom_en_i)      inst_o = hold_inst_q;
      else if (!fetch_bad) inst_o = mem[idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hold_core_q <= 1'b1;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      hold_inst_q <= NOP;
    end else begin
      state_q     <= state_n;
      hold_core_q <= (state_n != S_RUN);
      if (load_entry) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        if (beat) begin
          if (cnt_full) ovf_q <= 1'b1;
          else          cnt_q <= cnt_q + 1'b1;
        end
        if ((state_q == S_RUN) && rom_en_i && fetch_bad) err_q <= 1'b1;
      end
      if (rom_en_i) hold_inst_q <= inst_o;
    end
  end

  // NOTE: the memory has no reset; its contents survive rst by design, and a
  // reset port would prevent mapping it onto a RAM macro.
  always_ff @(posedge clk) begin
    if (beat && !cnt_full) mem[cnt_q[AW-1:0]] <= ld_data_i;
  end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Self-checking bench for inst_rom_ctrl (AW=2): directed vector table for the
// main load/fetch flow plus hand-written overflow and mid-load reset sequences.
module tb_inst_rom_ctrl;

  localparam int          AW  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] addr;
    logic        en;
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic [31:0] e_inst;
    logic        e_ready;
    logic        e_done;
    logic [AW:0] e_cnt;
    logic        e_ovf;
    logic        e_err;
    logic        e_hold;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [31:0]   rom_addr;
  logic          rom_en;
  logic [31:0]   inst;
  logic          ld_start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;
  logic [AW:0]   ld_cnt;
  logic          ld_ovf;
  logic          addr_err;
  logic          core_hold;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  inst_rom_ctrl #(.AW(AW), .NOP(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr_i  (rom_addr),
    .rom_en_i    (rom_en),
    .inst_o      (inst),
    .ld_start_i  (ld_start),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_last_i   (ld_last),
    .ld_ready_o  (ld_ready),
    .ld_done_o   (ld_done),
    .ld_cnt_o    (ld_cnt),
    .ld_ovf_o    (ld_ovf),
    .addr_err_o  (addr_err),
    .core_hold_o (core_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic r, input logic [31:0] a,
                              input logic e, input logic s, input logic v,
                              input logic [31:0] d, input logic l,
                              input logic [31:0] ei, input logic erdy, input logic edn,
                              input logic [AW:0] ec, input logic eo, input logic ee,
                              input logic eh);
    vec_t x;
    x.name = nm; x.rst = r; x.addr = a; x.en = e; x.start = s; x.valid = v;
    x.data = d; x.last = l; x.e_inst = ei; x.e_ready = erdy; x.e_done = edn;
    x.e_cnt = ec; x.e_ovf = eo; x.e_err = ee; x.e_hold = eh;
    return x;
  endfunction

  // Drive one cycle of inputs after the falling edge, check outputs before the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; rom_addr = v.addr; rom_en = v.en; ld_start = v.start;
    ld_valid = v.valid; ld_data = v.data; ld_last = v.last;
    #2;
    check({v.name, ".inst"},  inst,              v.e_inst);
    check({v.name, ".ready"}, 32'(ld_ready),     32'(v.e_ready));
    check({v.name, ".done"},  32'(ld_done),      32'(v.e_done));
    check({v.name, ".cnt"},   32'(ld_cnt),       32'(v.e_cnt));
    check({v.name, ".ovf"},   32'(ld_ovf),       32'(v.e_ovf));
    check({v.name, ".err"},   32'(addr_err),     32'(v.e_err));
    check({v.name, ".hold"},  32'(core_hold),    32'(v.e_hold));
  endtask

  task automatic step(input string nm, input logic r, input logic [31:0] a,
                      input logic e, input logic s, input logic v,
                      input logic [31:0] d, input logic l,
                      input logic [31:0] ei, input logic erdy, input logic edn,
                      input logic [AW:0] ec, input logic eo, input logic ee,
                      input logic eh);
    apply(mk(nm, r, a, e, s, v, d, l, ei, erdy, edn, ec, eo, ee, eh));
  endtask

  function automatic logic [31:0] w(input logic [31:0] base, input int i);
    return base + 32'(i);
  endfunction

  initial begin
    rst = 1'b1; rom_addr = '0; rom_en = 1'b0; ld_start = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    repeat (2) @(posedge clk);

    // T1: reset state, load A0..A3, done pulse, hold release, fetch 0x8
    //          name       rst addr  en s  v  data          l  inst          rdy dn cnt ovf err hold
    vecs.push_back(mk("t1_rst",   0, 0,    0, 1, 0, 0,             0, NOP,          0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t1_b0",    0, 0,    0, 0, 1, w(32'hA000_0000,0), 0, NOP,     1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t1_b1",    0, 0,    0, 0, 1, w(32'hA000_0000,1), 0, NOP,     1, 0, 1, 0, 0, 1));
    vecs.push_back(mk("t1_b2",    0, 0,    0, 0, 1, w(32'hA000_0000,2), 0, NOP,     1, 0, 2, 0, 0, 1));
    vecs.push_back(mk("t1_b3",    0, 0,    0, 0, 1, w(32'hA000_0000,3), 1, NOP,     1, 0, 3, 0, 0, 1));
    vecs.push_back(mk("t1_done",  0, 0,    0, 0, 0, 0,             0, NOP,          0, 1, 4, 0, 0, 1));
    vecs.push_back(mk("t1_f8",    0, 8,    1, 0, 0, 0,             0, 32'hA000_0002, 0, 0, 4, 0, 0, 0));
    // T4: fetch 0x4 then stall while the address moves
    vecs.push_back(mk("t4_f4",    0, 4,    1, 0, 0, 0,             0, 32'hA000_0001, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk("t4_s0",    0, 'hC,  0, 0, 0, 0,             0, 32'hA000_0001, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk("t4_s1",    0, 'hC,  0, 0, 0, 0,             0, 32'hA000_0001, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk("t4_s2",    0, 'hC,  0, 0, 0, 0,             0, 32'hA000_0001, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk("t4_fc",    0, 'hC,  1, 0, 0, 0,             0, 32'hA000_0003, 0, 0, 4, 0, 0, 0));
    // T5: misaligned and out-of-range fetches, sticky error, later valid fetch
    vecs.push_back(mk("t5_mis",   0, 6,    1, 0, 0, 0,             0, NOP,          0, 0, 4, 0, 0, 0));
    vecs.push_back(mk("t5_oor",   0, 16,   1, 0, 0, 0,             0, NOP,          0, 0, 4, 0, 1, 0));
    vecs.push_back(mk("t5_ok",    0, 0,    1, 0, 0, 0,             0, 32'hA000_0000, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mk("t5_stall", 0, 0,    0, 0, 0, 0,             0, 32'hA000_0000, 0, 0, 4, 0, 1, 0));
    // T2: reload from RUN with gaps in valid; start ignored in LOAD/DONE
    vecs.push_back(mk("t2_start", 0, 0,    0, 1, 1, 32'hDEAD_BEEF, 0, 32'hA000_0000, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mk("t2_b0",    0, 0,    0, 0, 1, w(32'hB000_0000,0), 0, NOP,     1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t2_gap0",  0, 0,    0, 1, 0, 32'hDEAD_BEEF, 0, NOP,          1, 0, 1, 0, 0, 1));
    vecs.push_back(mk("t2_b1",    0, 0,    0, 0, 1, w(32'hB000_0000,1), 0, NOP,     1, 0, 1, 0, 0, 1));
    vecs.push_back(mk("t2_gap1",  0, 0,    0, 0, 0, 32'hDEAD_BEEF, 0, NOP,          1, 0, 2, 0, 0, 1));
    vecs.push_back(mk("t2_b2",    0, 0,    0, 0, 1, w(32'hB000_0000,2), 1, NOP,     1, 0, 2, 0, 0, 1));
    vecs.push_back(mk("t2_done",  0, 0,    0, 1, 1, 32'hDEAD_BEEF, 0, NOP,          0, 1, 3, 0, 0, 1));
    vecs.push_back(mk("t2_f0",    0, 0,    1, 0, 0, 0,             0, 32'hB000_0000, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk("t2_f8",    0, 8,    1, 0, 0, 0,             0, 32'hB000_0002, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk("t2_fc",    0, 'hC,  1, 0, 0, 0,             0, 32'hA000_0003, 0, 0, 3, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // T3: 6-word image into a 4-word memory
    step("t3_start", 0, 'hC, 0, 1, 0, 0, 0, 32'hA000_0003, 0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step($sformatf("t3_b%0d", i), 0, 0, 0, 0, 1, w(32'hC000_0000, i), (i == 5),
           NOP, 1, 0, (i < 4) ? 3'(i) : 3'd4, (i == 5), 0, 1);
    step("t3_done", 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1, 4, 1, 0, 1);
    for (int i = 0; i < 4; i++)
      step($sformatf("t3_f%0d", i), 0, 32'(4 * i), 1, 0, 0, 0, 0,
           w(32'hC000_0000, i), 0, 0, 4, 1, 0, 0);

    // T6: reset after two beats, then a fresh full load
    step("t6_start", 0, 'hC, 1, 1, 0, 0, 0, 32'hC000_0003, 0, 0, 4, 1, 0, 0);
    step("t6_b0",    0, 0, 1, 0, 1, w(32'hD000_0000, 0), 0, NOP, 1, 0, 0, 0, 0, 1);
    step("t6_b1",    0, 0, 1, 0, 1, w(32'hD000_0000, 1), 0, NOP, 1, 0, 1, 0, 0, 1);
    step("t6_rst",   1, 0, 1, 0, 1, w(32'hD000_0000, 2), 0, NOP, 1, 0, 2, 0, 0, 1);
    step("t6_held",  0, 0, 1, 0, 1, w(32'hD000_0000, 3), 1, NOP, 0, 0, 0, 0, 0, 1);
    step("t6_rest",  0, 0, 1, 1, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      step($sformatf("t6_e%0d", i), 0, 0, 0, 0, 1, w(32'hE000_0000, i), (i == 3),
           NOP, 1, 0, 3'(i), 0, 0, 1);
    step("t6_done",  0, 0, 0, 0, 0, 0, 0, NOP, 0, 1, 4, 0, 0, 1);
    step("t6_f0",    0, 0,   1, 0, 0, 0, 0, 32'hE000_0000, 0, 0, 4, 0, 0, 0);
    step("t6_fc",    0, 'hC, 1, 0, 0, 0, 0, 32'hE000_0003, 0, 0, 4, 0, 0, 0);
    step("t6_f4",    0, 4,   1, 0, 0, 0, 0, 32'hE000_0001, 0, 0, 4, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
